router_pkt_tx: RTL and testbench

- Packet transmitter that drives the 1x3 router's input port.
- Accepts a command (destination address, payload length) and the payload bytes from an upstream source, buffers the whole payload, then serialises it as header, payload and parity with pkt_valid framing.
- Honours the router's busy back-pressure.
- Used as the stimulus and traffic source at the router input.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_tx_buf.sv | 65 ++++++
 rtl/router_pkt_tx.sv | 161 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and framing helpers for the router packet transmitter.
package router_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, GAP} state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int PTR_W        = 6;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] h;
        h = '0;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return h;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: one write port, one registered read port with a pre-advanced
// read address so the next byte is waiting one cycle after every transfer.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_adv,
    output logic [7:0] rd_data
);

    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(MAX_LEN - 1);

    logic [7:0]       mem [0:MAX_LEN-1];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_addr;

    always_comb begin
        rd_addr = rd_ptr_reg;
        if (clr) begin
            rd_addr = '0;
        end else if (rd_adv) begin
            rd_addr = rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (clr) begin
                wr_ptr_reg <= '0;
            end else if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Write-first forwarding covers a one-byte payload, whose only byte is
    // written on the same edge that must already fetch it for the header stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (wr_en && (wr_ptr_reg == rd_addr)) begin
            rd_data <= wr_data;
        end else if (rd_addr <= LAST_ADDR) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input: buffers a whole payload, then
// sends header, payload and parity with pkt_valid framing under busy back-pressure.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN  = 63,
    parameter int IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_corrupt,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       cmd_err
);

    localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);

    state_t     state_reg;
    logic       cmd_ready_reg;
    logic       pl_ready_reg;
    logic       pkt_valid_reg;
    logic       pkt_done_reg;
    logic       cmd_err_reg;
    logic [7:0] data_out_reg;
    logic [7:0] parity_reg;
    logic [1:0] addr_reg;
    logic [5:0] len_reg;
    logic [5:0] cnt_reg;
    logic [7:0] gap_reg;

    logic       cmd_fire;
    logic       cmd_legal;
    logic       pl_fire;
    logic       xfer;
    logic       rd_adv;
    logic [7:0] rd_data;

    assign cmd_fire  = (state_reg == IDLE) && cmd_valid && cmd_ready_reg;
    assign cmd_legal = (cmd_addr != ADDR_INVALID) && (cmd_len != 6'd0);
    assign pl_fire   = (state_reg == LOAD) && pl_valid && pl_ready_reg;
    assign xfer      = !busy && (state_reg inside {HDR, PAY, PAR});
    assign rd_adv    = !busy && (state_reg inside {HDR, PAY});

    router_tx_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (cmd_fire && cmd_legal),
        .wr_en   (pl_fire),
        .wr_data (pl_data),
        .rd_adv  (rd_adv),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            pl_ready_reg  <= 1'b0;
            pkt_valid_reg <= 1'b0;
            pkt_done_reg  <= 1'b0;
            cmd_err_reg   <= 1'b0;
            data_out_reg  <= '0;
            parity_reg    <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            gap_reg       <= '0;
        end else begin
            pkt_done_reg <= 1'b0;
            cmd_err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_fire) begin
                        addr_reg <= cmd_addr;
                        len_reg  <= cmd_len;
                        if (!cmd_legal) begin
                            cmd_err_reg <= 1'b1;
                        end else begin
                            // XOR is linear, so the corrupt inversion can be folded in up front.
                            parity_reg    <= make_header(cmd_len, cmd_addr) ^ {8{cmd_corrupt}};
                            cnt_reg       <= '0;
                            cmd_ready_reg <= 1'b0;
                            pl_ready_reg  <= 1'b1;
                            state_reg     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (pl_fire) begin
                        parity_reg <= parity_reg ^ pl_data;
                        if (cnt_reg == len_reg - 6'd1) begin
                            pl_ready_reg  <= 1'b0;
                            cnt_reg       <= '0;
                            data_out_reg  <= make_header(len_reg, addr_reg);
                            pkt_valid_reg <= 1'b1;
                            state_reg     <= HDR;
                        end else begin
                            cnt_reg <= cnt_reg + 6'd1;
                        end
                    end
                end
                HDR: begin
                    if (xfer) begin
                        data_out_reg <= rd_data;
                        state_reg    <= PAY;
                    end
                end
                PAY: begin
                    if (xfer) begin
                        if (cnt_reg == len_reg - 6'd1) begin
                            data_out_reg  <= parity_reg;
                            pkt_valid_reg <= 1'b0;
                            state_reg     <= PAR;
                        end else begin
                            data_out_reg <= rd_data;
                            cnt_reg      <= cnt_reg + 6'd1;
                        end
                    end
                end
                PAR: begin
                    if (xfer) begin
                        data_out_reg <= '0;
                        pkt_done_reg <= 1'b1;
                        gap_reg      <= '0;
                        state_reg    <= GAP;
                    end
                end
                GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        gap_reg <= gap_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign pl_ready  = pl_ready_reg;
    assign pkt_valid = pkt_valid_reg;
    assign data_out  = data_out_reg;
    assign pkt_done  = pkt_done_reg;
    assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised self-checking bench for router_pkt_tx against a byte-stream
// reference model of the packet format and handshake rules.
module tb_router_pkt_tx;

    localparam int MAX_LEN  = 63;
    localparam int IDLE_GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_corrupt;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       pkt_done;
    logic       cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    router_pkt_tx #(
        .MAX_LEN  (MAX_LEN),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_corrupt (cmd_corrupt),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .pl_data     (pl_data),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .pkt_done    (pkt_done),
        .cmd_err     (cmd_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // busy_mode: 0 never busy, 1 random, 2 scripted stalls on header and payload byte 2.
    // pl_kind: 0 random bytes, 1 0x11,0x22,.., 2 ramp 0,1,2,..
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic corrupt,
                            input int busy_mode, input int abort_at, input int pl_kind);
        logic [7:0] pl_q[$];
        logic [7:0] exp_q[$];
        logic [7:0] par;
        logic [7:0] prev_data;
        logic       prev_valid;
        bit         prev_busy, prev_shown, shown, was_acc;
        bit         accepted, hdr_due, last_acc, par_sent, done;
        int         idx, pl_idx, since_par, hstall, bstall, len_i;
        string      tag;

        len_i = int'(l);
        for (int i = 0; i < len_i; i++) begin
            case (pl_kind)
                1:       pl_q.push_back(8'((i + 1) * 17));
                2:       pl_q.push_back(8'(i));
                default: pl_q.push_back(8'($urandom));
            endcase
        end
        par = {l, a};
        exp_q.push_back(par);
        foreach (pl_q[i]) begin
            exp_q.push_back(pl_q[i]);
            par = par ^ pl_q[i];
        end
        exp_q.push_back(corrupt ? ~par : par);

        idx = 0; pl_idx = 0; since_par = 0; hstall = 0; bstall = 0;
        accepted = 0; hdr_due = 0; last_acc = 0; par_sent = 0; done = 0;
        prev_busy = 0; prev_shown = 0; prev_valid = 0; prev_data = '0;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_corrupt = corrupt;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            was_acc = accepted;
            if (last_acc) hdr_due = 1;
            shown = hdr_due && (idx <= len_i + 1);

            if (prev_busy && prev_shown) begin
                chk("hold_data", data_out, prev_data);
                chk("hold_valid", pkt_valid, prev_valid);
            end

            if (abort_at >= 0 && idx == abort_at) begin
                busy = 1'b0; pl_valid = 1'b0; cmd_valid = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("rst_valid", pkt_valid, 0);
                chk("rst_data", data_out, 0);
                chk("rst_cmd_ready", cmd_ready, 0);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("ready_after_rst", cmd_ready, 1);
                $display("pkt addr=%0d len=%0d aborted by reset after %0d bytes", a, l, idx);
                return;
            end

            chk("cmd_err_legal", cmd_err, 0);
            if (par_sent) begin
                since_par++;
                chk("pkt_done", pkt_done, since_par == 1);
                if (since_par <= IDLE_GAP) begin
                    chk("gap_valid", pkt_valid, 0);
                    chk("gap_data", data_out, 0);
                    chk("gap_cmd_ready", cmd_ready, 0);
                end else begin
                    chk("ready_after_gap", cmd_ready, 1);
                    done = 1;
                end
            end else begin
                chk("pkt_done_early", pkt_done, 0);
                if (was_acc) chk("cmd_ready_busy", cmd_ready, 0);
            end
            if (!hdr_due) chk("early_valid", pkt_valid, 0);

            case (busy_mode)
                1: busy = ($urandom_range(3) == 0);
                2: begin
                    busy = 1'b0;
                    if (shown && idx == 0 && hstall < 3) begin
                        busy = 1'b1; hstall++;
                    end else if (shown && idx == 2 && bstall < 2) begin
                        busy = 1'b1; bstall++;
                    end
                end
                default: busy = 1'b0;
            endcase

            if (pl_idx < len_i) begin
                pl_valid = ($urandom_range(3) != 0);
                pl_data  = pl_q[pl_idx];
            end else begin
                pl_valid = ($urandom_range(1) == 1);
                pl_data  = 8'($urandom);
            end

            if (!was_acc) begin
                chk("pl_ready_idle", pl_ready, 0);
                if (cmd_ready) accepted = 1;
            end else if (!done) begin
                cmd_valid   = ($urandom_range(1) == 1);
                cmd_addr    = 2'($urandom);
                cmd_len     = 6'($urandom);
                cmd_corrupt = ($urandom_range(1) == 1);
            end

            last_acc = 0;
            if (was_acc && pl_idx < len_i) begin
                if (pl_valid && pl_ready) begin
                    pl_idx++;
                    if (pl_idx == len_i) last_acc = 1;
                end
            end else if (was_acc) begin
                chk("pl_ready_after_load", pl_ready, 0);
            end

            if (shown) begin
                chk(idx <= len_i ? "valid_high" : "valid_parity", pkt_valid, idx <= len_i);
                if (!busy) begin
                    if (idx == 0) tag = "header";
                    else if (idx == len_i + 1) tag = "parity";
                    else tag = "payload";
                    chk(tag, data_out, exp_q[idx]);
                    idx++;
                    if (idx == len_i + 2) par_sent = 1;
                end
            end

            if (done) begin
                cmd_valid = 1'b0; pl_valid = 1'b0; busy = 1'b0;
            end
            prev_busy  = busy;
            prev_shown = shown;
            prev_data  = data_out;
            prev_valid = pkt_valid;
            if (!done) @(negedge clk);
        end
        if (!done) chk("timeout", 0, 1);
        $display("pkt addr=%0d len=%0d corrupt=%0d busy_mode=%0d bytes=%0d parity=0x%02h",
                 a, l, corrupt, busy_mode, idx, exp_q[len_i + 1]);
    endtask

    task automatic send_bad(input logic [1:0] a, input logic [5:0] l);
        bit fired;
        fired = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_corrupt = 1'b0;
        for (int cyc = 0; cyc < 20 && !fired; cyc++) begin
            if (cmd_ready) fired = 1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("bad_accepted", fired, 1);
        chk("cmd_err_pulse", cmd_err, 1);
        for (int cyc = 0; cyc < int'(l) + 10; cyc++) begin
            pl_valid = 1'b1;
            pl_data  = 8'($urandom);
            busy     = ($urandom_range(1) == 1);
            @(negedge clk);
            chk("bad_pkt_valid", pkt_valid, 0);
            chk("bad_pl_ready", pl_ready, 0);
            chk("bad_err_once", cmd_err, 0);
            chk("bad_cmd_ready", cmd_ready, 1);
        end
        pl_valid = 1'b0; busy = 1'b0;
        $display("bad cmd addr=%0d len=%0d rejected", a, l);
    endtask

    initial begin
        logic [1:0] ra;
        logic [5:0] rl;
        logic       rc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_corrupt = 1'b0;
        pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_pl_ready", pl_ready, 0);
        chk("reset_pkt_valid", pkt_valid, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_pkt_done", pkt_done, 0);
        chk("reset_cmd_err", cmd_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        send_pkt(2'd1, 6'd3, 1'b0, 0, -1, 1);
        send_pkt(2'd1, 6'd3, 1'b0, 2, -1, 1);
        send_bad(2'd3, 6'd5);
        send_bad(2'd0, 6'd0);
        send_pkt(2'd2, 6'd63, 1'b0, 0, -1, 2);
        send_pkt(2'd1, 6'd3, 1'b1, 0, -1, 1);
        send_pkt(2'd0, 6'd1, 1'b0, 1, -1, 0);
        send_pkt(2'd1, 6'd3, 1'b0, 0, 2, 1);
        send_pkt(2'd1, 6'd3, 1'b0, 0, -1, 1);
        for (int n = 0; n < 25; n++) begin
            ra = 2'($urandom_range(2));
            rl = 6'($urandom_range(63, 1));
            rc = ($urandom_range(3) == 0);
            send_pkt(ra, rl, rc, 1, -1, 0);
        end
        send_pkt(2'd2, 6'd63, 1'b1, 1, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
